// File: rtl/riscv_scoreboard_hu.sv
// ----------------------------------------------------------------------------
// riscv_scoreboard_hu
//   Shift-register scoreboard / hazard unit for an in-order pipeline.
//   It tracks in-flight register writes for DEPTH stages after execute
//   (position 1 = MEM, position DEPTH = WB). For every source operand of the
//   instruction entering execute it picks a register-file read or a bypass
//   position. When a producer's result is not yet bypassable (load-use or
//   multi-cycle producer), it raises a stall. The unit also honours pipeline
//   hold and flush, and keeps saturating stall and forward counters.
//
// Ports
//   i_clk         clock
//   i_reset       synchronous, active-high reset
//   i_iss_valid   instruction presented to EX this cycle
//   i_iss_rs      source register addresses; operand k is [k*AW +: AW]
//   i_iss_rd      destination register
//   i_iss_we      instruction writes i_iss_rd
//   i_iss_avail   first position (1..DEPTH) at which the result is bypassable
//   i_pipe_hold   downstream busy; scoreboard frozen this cycle
//   i_flush       redirect from EX; the instruction being issued is killed
//   o_iss_stall   issue must not proceed this cycle
//   o_iss_fire    i_iss_valid & ~o_iss_stall & ~i_flush
//   o_src_sel     per operand: 0 = RF, p = bypass from position p
//   o_stall_cnt   cycles with i_iss_valid & o_iss_stall (saturating)
//   o_fwd_cnt     fired instructions with any non-zero select (saturating)
// ----------------------------------------------------------------------------
module riscv_scoreboard_hu #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int DEPTH   = 2,
    parameter int SW      = 2,
    parameter int CNT_W   = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_iss_valid,
    input  logic [NUM_SRC*AW-1:0]   i_iss_rs,
    input  logic [AW-1:0]           i_iss_rd,
    input  logic                    i_iss_we,
    input  logic [SW-1:0]           i_iss_avail,
    input  logic                    i_pipe_hold,
    input  logic                    i_flush,
    output logic                    o_iss_stall,
    output logic                    o_iss_fire,
    output logic [NUM_SRC*SW-1:0]   o_src_sel,
    output logic [CNT_W-1:0]        o_stall_cnt,
    output logic [CNT_W-1:0]        o_fwd_cnt
);

    localparam logic [SW-1:0]    LP_DEPTH = SW'(DEPTH);
    localparam logic [SW-1:0]    LP_ONE   = SW'(1);
    localparam logic [CNT_W-1:0] LP_CINC  = CNT_W'(1);

    // Scoreboard entries, index 1 is the youngest (MEM) position.
    logic            r_v     [1:DEPTH];
    logic [AW-1:0]   r_rd    [1:DEPTH];
    logic            r_we    [1:DEPTH];
    logic [SW-1:0]   r_avail [1:DEPTH];

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;

    logic [NUM_SRC-1:0] w_haz;
    logic               w_any_haz;
    logic               w_any_fwd;
    logic [SW-1:0]      w_avail_clamp;

    // Per-operand lookup. Scanning from the oldest position down to the
    // youngest lets the youngest match overwrite any older one.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [AW-1:0] w_rs;
            logic [SW-1:0] w_sel;
            logic          w_hz;

            assign w_rs = i_iss_rs[gi*AW +: AW];

            always_comb begin
                w_sel = '0;
                w_hz  = 1'b0;
                if (w_rs != '0) begin
                    for (int p = DEPTH; p >= 1; p--) begin
                        if (r_v[p] && r_we[p] && (r_rd[p] == w_rs)) begin
                            if (SW'(p) >= r_avail[p]) begin
                                w_sel = SW'(p);
                                w_hz  = 1'b0;
                            end else begin
                                w_sel = '0;
                                w_hz  = 1'b1;
                            end
                        end
                    end
                end
            end

            assign o_src_sel[gi*SW +: SW] = w_sel;
            assign w_haz[gi]              = w_hz;
        end
    endgenerate

    assign w_any_haz   = |w_haz;
    assign w_any_fwd   = |o_src_sel;
    assign o_iss_stall = i_pipe_hold | (i_iss_valid & w_any_haz);
    assign o_iss_fire  = i_iss_valid & ~o_iss_stall & ~i_flush;
    assign o_stall_cnt = r_stall_cnt;
    assign o_fwd_cnt   = r_fwd_cnt;

    // A producer can never be bypassable before MEM nor later than WB.
    always_comb begin
        w_avail_clamp = i_iss_avail;
        if (i_iss_avail == '0) begin
            w_avail_clamp = LP_ONE;
        end else if (i_iss_avail > LP_DEPTH) begin
            w_avail_clamp = LP_DEPTH;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int p = 1; p <= DEPTH; p++) begin
                r_v[p]     <= 1'b0;
                r_rd[p]    <= '0;
                r_we[p]    <= 1'b0;
                r_avail[p] <= LP_ONE;
            end
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            // Stall cycles are counted even while the pipe is held.
            if (i_iss_valid && o_iss_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + LP_CINC;
            end
            if (!i_pipe_hold) begin
                for (int p = DEPTH; p >= 2; p--) begin
                    r_v[p]     <= r_v[p-1];
                    r_rd[p]    <= r_rd[p-1];
                    r_we[p]    <= r_we[p-1];
                    r_avail[p] <= r_avail[p-1];
                end
                // Stalled or flushed issue slots enter as bubbles (v=0).
                // Writes to x0 are recorded as non-writing so they never match.
                r_v[1]     <= o_iss_fire;
                r_rd[1]    <= i_iss_rd;
                r_we[1]    <= i_iss_we && (i_iss_rd != '0);
                r_avail[1] <= w_avail_clamp;
                if (o_iss_fire && w_any_fwd && (r_fwd_cnt != '1)) begin
                    r_fwd_cnt <= r_fwd_cnt + LP_CINC;
                end
            end
        end
    end

endmodule
